// File: rtl/sd_card_responder_if.sv
// sd_card_responder_if: SD CMD-line pins plus the command/response handshake
// between the responder and a local card model.
interface sd_card_responder_if;
  logic        i_sd_clk;
  logic        i_sd_cmd;
  logic        o_sd_cmd;
  logic        o_sd_cmd_oe;
  logic        o_cmd_valid;
  logic [5:0]  o_cmd_index;
  logic [31:0] o_cmd_arg;
  logic        i_resp_valid;
  logic        i_resp_none;
  logic [5:0]  i_resp_index;
  logic [31:0] i_resp_data;
  logic        o_error;

  modport slave (
    input  i_sd_clk, i_sd_cmd, i_resp_valid, i_resp_none, i_resp_index, i_resp_data,
    output o_sd_cmd, o_sd_cmd_oe, o_cmd_valid, o_cmd_index, o_cmd_arg, o_error
  );

  modport master (
    output i_sd_clk, i_sd_cmd, i_resp_valid, i_resp_none, i_resp_index, i_resp_data,
    input  o_sd_cmd, o_sd_cmd_oe, o_cmd_valid, o_cmd_index, o_cmd_arg, o_error
  );
endinterface

// File: rtl/sd_card_responder.sv
// sd_card_responder: card-side SD CMD-line responder (deframe, hand off, reply).
// Define SD_RESPONDER_CRC_CHECK_EN to drop received frames whose CRC7 mismatches.
module sd_card_responder #(
  parameter int NCR = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  sd_card_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RECV, PEND, NCR_WAIT, SEND} state_t;

  localparam logic [6:0] NCR_LAST = 7'(NCR - 1);
  localparam logic [6:0] NCR_DONE = 7'(NCR);

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  function automatic logic [6:0] crc7_block(input logic [39:0] bits);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, bits[i]);
    return c;
  endfunction

  state_t      state_q, state_d;
  logic        sclk_p0, sclk_p1, sclk_p2, cmd_p0, cmd_p1;
  logic        rise, fall;
  logic [5:0]  bit_cnt_q;
  logic [6:0]  ncr_cnt_q;
  logic [37:0] rx_sh_q;
  logic [47:0] tx_sh_q;
  logic [39:0] resp_body;
  logic        drop_frame, crc_bad, err_q;
  logic        cmd_q, cmd_oe_q;
  logic [5:0]  index_q;
  logic [31:0] arg_q;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous SD_CLK for edge detect
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cmd_p0  <= 1'b1;
      cmd_p1  <= 1'b1;
    end else begin
      sclk_p0 <= bus.i_sd_clk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cmd_p0  <= bus.i_sd_cmd;
      cmd_p1  <= cmd_p0;
    end
  end

  assign rise = sclk_p1 & ~sclk_p2;
  assign fall = ~sclk_p1 & sclk_p2;

`ifdef SD_RESPONDER_CRC_CHECK_EN
  logic [6:0] rx_crc_calc_q, rx_crc_field_q;

  always_ff @(posedge i_clock) begin
    if (state_q == IDLE && rise && !cmd_p1) rx_crc_calc_q <= '0;
    else if (state_q == RECV && rise) begin
      if (bit_cnt_q <= 6'd39) rx_crc_calc_q <= crc7_step(rx_crc_calc_q, cmd_p1);
      if (bit_cnt_q >= 6'd40 && bit_cnt_q <= 6'd46) rx_crc_field_q <= {rx_crc_field_q[5:0], cmd_p1};
    end
  end

  assign crc_bad = (rx_crc_calc_q != rx_crc_field_q);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    drop_frame = 1'b0;
    case (state_q)
      IDLE: if (rise && !cmd_p1) state_d = RECV;
      RECV: if (rise) begin
        // A zero transmission bit is another card's response, not ours to flag
        if (bit_cnt_q == 6'd1 && !cmd_p1) state_d = IDLE;
        else if (bit_cnt_q == 6'd47) begin
          if (!cmd_p1 || crc_bad) begin
            state_d    = IDLE;
            drop_frame = 1'b1;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND:     if (bus.i_resp_valid) state_d = bus.i_resp_none ? IDLE : NCR_WAIT;
      NCR_WAIT: if (fall && ncr_cnt_q == NCR_DONE) state_d = SEND;
      SEND:     if (fall && bit_cnt_q == 6'd48) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_cmd_valid = (state_q == PEND);
    bus.o_error     = err_q;
    bus.o_sd_cmd    = cmd_q;
    bus.o_sd_cmd_oe = cmd_oe_q;
    bus.o_cmd_index = index_q;
    bus.o_cmd_arg   = arg_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bit_cnt_q <= '0;
      ncr_cnt_q <= '0;
      err_q     <= 1'b0;
      cmd_q     <= 1'b1;
      cmd_oe_q  <= 1'b0;
      index_q   <= '0;
      arg_q     <= '0;
    end else begin
      err_q <= drop_frame;
      case (state_q)
        IDLE: if (rise && !cmd_p1) bit_cnt_q <= 6'd1;
        RECV: if (rise) begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (state_d == PEND) begin
            index_q <= rx_sh_q[37:32];
            arg_q   <= rx_sh_q[31:0];
          end
        end
        PEND: ncr_cnt_q <= '0;
        NCR_WAIT: if (fall) begin
          ncr_cnt_q <= ncr_cnt_q + 7'd1;
          if (ncr_cnt_q == NCR_LAST) begin
            cmd_oe_q <= 1'b1;
            cmd_q    <= 1'b1;
          end
          if (ncr_cnt_q == NCR_DONE) begin
            cmd_q     <= tx_sh_q[47];
            bit_cnt_q <= 6'd1;
          end
        end
        SEND: if (fall) begin
          if (bit_cnt_q == 6'd48) begin
            cmd_oe_q <= 1'b0;
            cmd_q    <= 1'b1;
          end else begin
            cmd_q     <= tx_sh_q[47];
            bit_cnt_q <= bit_cnt_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_body = {2'b00, bus.i_resp_index, bus.i_resp_data};

  // Only index and argument bits (2..39) are kept; the CRC field is consumed by the counter
  always_ff @(posedge i_clock) begin
    if (state_q == RECV && rise && bit_cnt_q >= 6'd2 && bit_cnt_q <= 6'd39)
      rx_sh_q <= {rx_sh_q[36:0], cmd_p1};
    if (state_q == PEND && bus.i_resp_valid && !bus.i_resp_none)
      tx_sh_q <= {resp_body, crc7_block(resp_body), 1'b1};
    else if (fall && ((state_q == NCR_WAIT && ncr_cnt_q == NCR_DONE) || state_q == SEND))
      tx_sh_q <= {tx_sh_q[46:0], 1'b0};
  end

endmodule

// File: tb/tb_sd_card_responder.sv
// tb_sd_card_responder: directed host frames against a frame-level model of the
// expected CMD-line drive, counted in SD_CLK falls after the card model accepts.
module tb_sd_card_responder;
  localparam int NCR = 2;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;

  sd_card_responder_if sd_if();

  sd_card_responder #(.NCR(NCR)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (sd_if)
  );

  always #5 i_clock = ~i_clock;

  int          n_checks   = 0;
  int          n_errors   = 0;
  int          err_pulses = 0;
  int          nf         = -1;
  logic        cmp_en     = 1'b0;
  logic [47:0] exp_frame  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [39:0] m);
    int r;
    r = 0;
    for (int i = 39; i >= 0; i--) begin
      if (((r >> 6) & 1) != int'(m[i])) r = ((r << 1) & 127) ^ 9;
      else                              r = (r << 1) & 127;
    end
    return 7'(r);
  endfunction

  // {oe, cmd} expected after the n-th SD_CLK fall following accept
  function automatic logic [1:0] exp_line(input int n, input logic [47:0] fr);
    if (n < NCR)       return 2'b01;
    if (n == NCR)      return 2'b11;
    if (n <= NCR + 48) return {1'b1, fr[47 - (n - NCR - 1)]};
    return 2'b01;
  endfunction

  task automatic tick();
    logic [1:0] e;
    @(negedge i_clock);
    if (sd_if.o_error) err_pulses++;
    if (cmp_en) begin
      e = exp_line(nf, exp_frame);
      check("cmd_oe", 64'(sd_if.o_sd_cmd_oe), 64'(e[1]));
      check("cmd_out", 64'(sd_if.o_sd_cmd), 64'(e[0]));
    end
  endtask

  task automatic sd_cycle(input logic b);
    sd_if.i_sd_clk = 1'b0;
    sd_if.i_sd_cmd = b;
    if (nf >= 0) nf++;
    cmp_en = 1'b0;
    repeat (3) tick();
    cmp_en = 1'b1;
    tick();
    sd_if.i_sd_clk = 1'b1;
    repeat (4) tick();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) sd_cycle(1'b1);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) sd_cycle(f[i]);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!sd_if.o_cmd_valid && k < 16) begin
      tick();
      k++;
    end
    check(name, 64'(sd_if.o_cmd_valid), 64'd1);
  endtask

  task automatic accept(input logic none, input logic [5:0] idx, input logic [31:0] data);
    sd_if.i_resp_valid = 1'b1;
    sd_if.i_resp_none  = none;
    sd_if.i_resp_index = idx;
    sd_if.i_resp_data  = data;
    tick();
    sd_if.i_resp_valid = 1'b0;
    sd_if.i_resp_none  = 1'b0;
    if (!none) begin
      exp_frame = {2'b00, idx, data, crc7_model({2'b00, idx, data}), 1'b1};
      nf = 0;
    end
    check("valid_clear", 64'(sd_if.o_cmd_valid), 64'd0);
  endtask

  initial begin
    int base;
    sd_if.i_sd_clk     = 1'b1;
    sd_if.i_sd_cmd     = 1'b1;
    sd_if.i_resp_valid = 1'b0;
    sd_if.i_resp_none  = 1'b0;
    sd_if.i_resp_index = '0;
    sd_if.i_resp_data  = '0;

    repeat (3) tick();
    check("rst_cmd", 64'(sd_if.o_sd_cmd), 64'd1);
    check("rst_oe", 64'(sd_if.o_sd_cmd_oe), 64'd0);
    check("rst_valid", 64'(sd_if.o_cmd_valid), 64'd0);
    check("rst_index", 64'(sd_if.o_cmd_index), 64'd0);
    check("rst_arg", 64'(sd_if.o_cmd_arg), 64'd0);
    check("rst_error", 64'(sd_if.o_error), 64'd0);

    check("crc_cmd0", 64'(crc7_model(40'h4000000000)), 64'h4A);
    check("crc_cmd8", 64'(crc7_model(40'h48000001AA)), 64'h43);
    check("crc_cmd55", 64'(crc7_model(40'h7700000000)), 64'h32);

    i_reset = 1'b0;
    idle_cycles(4);

    // CMD0, no response
    send_frame(48'h400000000095);
    wait_valid("cmd0_valid");
    check("cmd0_index", 64'(sd_if.o_cmd_index), 64'd0);
    check("cmd0_arg", 64'(sd_if.o_cmd_arg), 64'd0);
    accept(1'b1, 6'd0, 32'd0);
    idle_cycles(8);
    check("cmd0_no_error", 64'(err_pulses), 64'd0);

    // CMD8 with R7 reply; SD_CLK keeps running while pending
    nf = -1;
    send_frame(48'h48000001AA87);
    wait_valid("cmd8_valid");
    check("cmd8_index", 64'(sd_if.o_cmd_index), 64'd8);
    check("cmd8_arg", 64'(sd_if.o_cmd_arg), 64'h1AA);
    idle_cycles(3);
    check("cmd8_pend_hold", 64'(sd_if.o_cmd_valid), 64'd1);
    check("cmd8_pend_arg", 64'(sd_if.o_cmd_arg), 64'h1AA);
    accept(1'b0, 6'd8, 32'h000001AA);
    idle_cycles(NCR + 52);
    nf = -1;
    check("cmd8_no_error", 64'(err_pulses), 64'd0);

    // Stray accept strobe while idle must not start a response
    sd_if.i_resp_valid = 1'b1;
    sd_if.i_resp_index = 6'd8;
    tick();
    sd_if.i_resp_valid = 1'b0;
    idle_cycles(NCR + 6);

    // CMD55 carrying a corrupted CRC field
    base = err_pulses;
    send_frame(48'h770000000077);
    repeat (8) tick();
`ifdef SD_RESPONDER_CRC_CHECK_EN
    check("cmd55_crc_error", 64'(err_pulses), 64'(base + 1));
    check("cmd55_no_valid", 64'(sd_if.o_cmd_valid), 64'd0);
`else
    wait_valid("cmd55_valid");
    check("cmd55_index", 64'(sd_if.o_cmd_index), 64'd55);
    check("cmd55_arg", 64'(sd_if.o_cmd_arg), 64'd0);
    check("cmd55_no_error", 64'(err_pulses), 64'(base));
    accept(1'b1, 6'd0, 32'd0);
`endif
    idle_cycles(2);

    // CMD17 with end bit forced low
    base = err_pulses;
    send_frame({8'h51, 32'h00000000, 8'h54});
    repeat (8) tick();
    check("cmd17_end_error", 64'(err_pulses), 64'(base + 1));
    check("cmd17_no_valid", 64'(sd_if.o_cmd_valid), 64'd0);
    idle_cycles(2);

    // Frame with transmission bit 0 (looks like an R3 from another card)
    base = err_pulses;
    send_frame(48'h3FFFFFFFFFFF);
    idle_cycles(4);
    check("tx0_no_error", 64'(err_pulses), 64'(base));
    check("tx0_no_valid", 64'(sd_if.o_cmd_valid), 64'd0);

    // Reset while the response is on the line
    send_frame(48'h48000001AA87);
    wait_valid("cmd8b_valid");
    accept(1'b0, 6'd8, 32'h000001AA);
    idle_cycles(NCR + 10);
    check("mid_send_oe", 64'(sd_if.o_sd_cmd_oe), 64'd1);
    cmp_en  = 1'b0;
    nf      = -1;
    i_reset = 1'b1;
    #1;
    check("rst_send_oe", 64'(sd_if.o_sd_cmd_oe), 64'd0);
    check("rst_send_cmd", 64'(sd_if.o_sd_cmd), 64'd1);
    check("rst_send_valid", 64'(sd_if.o_cmd_valid), 64'd0);
    tick();
    tick();
    i_reset = 1'b0;
    idle_cycles(3);
    send_frame(48'h400000000095);
    wait_valid("cmd0b_valid");
    check("cmd0b_index", 64'(sd_if.o_cmd_index), 64'd0);
    check("cmd0b_arg", 64'(sd_if.o_cmd_arg), 64'd0);
    accept(1'b1, 6'd0, 32'd0);
    idle_cycles(4);

`ifdef SD_RESPONDER_CRC_CHECK_EN
    check("total_errors", 64'(err_pulses), 64'd2);
`else
    check("total_errors", 64'(err_pulses), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
